// File: rtl/mem_stream_reader.sv
// Burst read initiator: walks a strided, wrapping address sequence over an async-read
// memory and streams the fetched words out through a valid/ready register slice.
module mem_stream_reader #(
  parameter  int WIDTH     = 16,
  parameter  int HEIGHT    = 1024,
  parameter  int LEN_WIDTH = 16,
  localparam int AW        = $clog2(HEIGHT)
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic [AW-1:0]        cmd_stride,
  output logic [AW-1:0]        mem_read_addr,
  output logic                 mem_read_en,
  input  logic [WIDTH-1:0]     mem_qout,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [AW:0] HEIGHT_W = (AW+1)'(HEIGHT);

  logic [1:0]           state_q, state_d;
  logic [AW-1:0]        cur_addr_q, cur_addr_d;
  logic [AW-1:0]        stride_q, stride_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;

  logic          fire;
  logic [AW:0]   addr_sum;
  logic [AW-1:0] next_addr;

  // A word is captured only when the output slot is free or being emptied this cycle.
  assign fire = (state_q == READ) && (remaining_q != '0) && (!out_valid_q || out_ready);

  // One conditional subtract is enough because both operands are below HEIGHT.
  assign addr_sum  = {1'b0, cur_addr_q} + {1'b0, stride_q};
  assign next_addr = AW'((addr_sum >= HEIGHT_W) ? (addr_sum - HEIGHT_W) : addr_sum);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    stride_d    = stride_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len != '0) begin
            cur_addr_d  = cmd_addr;
            remaining_d = cmd_len;
            stride_d    = cmd_stride;
            state_d     = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (fire) begin
          out_data_d  = mem_qout;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == LEN_WIDTH'(1));
          remaining_d = remaining_q - LEN_WIDTH'(1);
          cur_addr_d  = next_addr;
          if (remaining_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      stride_q    <= stride_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign mem_read_en   = fire;
  assign mem_read_addr = cur_addr_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign done          = done_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench: a HEIGHT=16 reader for most scenarios, a HEIGHT=12 reader for wrap.
module tb_mem_stream_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_cmd_valid, a_cmd_ready, a_mem_read_en, a_out_valid, a_out_ready, a_out_last, a_busy, a_done;
  logic [3:0]  a_cmd_addr, a_cmd_stride, a_mem_read_addr;
  logic [15:0] a_cmd_len, a_mem_qout, a_out_data;
  logic        b_cmd_valid, b_cmd_ready, b_mem_read_en, b_out_valid, b_out_ready, b_out_last, b_busy, b_done;
  logic [3:0]  b_cmd_addr, b_cmd_stride, b_mem_read_addr;
  logic [15:0] b_cmd_len, b_mem_qout, b_out_data;

  // Memory models: mem[i] = i + 100, combinational read.
  assign a_mem_qout = 16'(a_mem_read_addr) + 16'd100;
  assign b_mem_qout = 16'(b_mem_read_addr) + 16'd100;

  mem_stream_reader #(.WIDTH(16), .HEIGHT(16), .LEN_WIDTH(16)) u_a (
    .clk(clk), .arst_n_in(rst_n), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_addr(a_cmd_addr), .cmd_len(a_cmd_len), .cmd_stride(a_cmd_stride),
    .mem_read_addr(a_mem_read_addr), .mem_read_en(a_mem_read_en), .mem_qout(a_mem_qout),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_last(a_out_last), .busy(a_busy), .done(a_done));

  mem_stream_reader #(.WIDTH(16), .HEIGHT(12), .LEN_WIDTH(16)) u_b (
    .clk(clk), .arst_n_in(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_addr(b_cmd_addr), .cmd_len(b_cmd_len), .cmd_stride(b_cmd_stride),
    .mem_read_addr(b_mem_read_addr), .mem_read_en(b_mem_read_en), .mem_qout(b_mem_qout),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_last(b_out_last), .busy(b_busy), .done(b_done));

  logic [3:0]  ra_q[$];
  logic [15:0] da_q[$];
  logic        la_q[$];
  int done_cnt, done_cyc, first_rd, first_ov, stall_cnt, hold_viol, busy_seen, done_rdy_bad, inv_bad;
  logic        stall_prev;
  logic [15:0] pd;
  logic        pl;

  logic [3:0]  rb_q[$];
  logic [15:0] db_q[$];
  int b_done_cnt;

  always @(negedge clk) begin
    if (a_mem_read_en) begin
      ra_q.push_back(a_mem_read_addr);
      if (first_rd < 0) first_rd = cyc;
    end
    if (a_out_valid && first_ov < 0) first_ov = cyc;
    if (a_out_valid && a_out_ready) begin
      da_q.push_back(a_out_data);
      la_q.push_back(a_out_last);
    end
    if (a_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (a_cmd_ready !== 1'b1) done_rdy_bad++;
    end
    if (a_busy) busy_seen++;
    if ((a_cmd_ready === a_busy) || (a_mem_read_en && !a_busy)) inv_bad++;
    if (stall_prev && (a_out_valid !== 1'b1 || a_out_data !== pd || a_out_last !== pl)) hold_viol++;
    stall_prev = a_out_valid && !a_out_ready;
    if (stall_prev) stall_cnt++;
    pd = a_out_data;
    pl = a_out_last;
    if (b_mem_read_en) rb_q.push_back(b_mem_read_addr);
    if (b_out_valid && b_out_ready) db_q.push_back(b_out_data);
    if (b_done) b_done_cnt++;
  end

  task automatic clear_mon();
    ra_q.delete(); da_q.delete(); la_q.delete(); rb_q.delete(); db_q.delete();
    done_cnt = 0; done_cyc = -1; first_rd = -1; first_ov = -1; stall_cnt = 0;
    hold_viol = 0; busy_seen = 0; done_rdy_bad = 0; stall_prev = 1'b0; b_done_cnt = 0;
  endtask

  task automatic send_a(input int addr, input int len, input int stride, output int t);
    int k;
    a_cmd_valid = 1'b1; a_cmd_addr = 4'(addr); a_cmd_len = 16'(len); a_cmd_stride = 4'(stride);
    k = 0;
    while (!a_cmd_ready && k < 100) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    t = cyc;
    a_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < 200 && done_cnt < n; k++) begin @(posedge clk); #1; end
    checks++;
    if (done_cnt < n) begin errors++; $display("FAIL done_timeout got %0d want %0d", done_cnt, n); end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_cmd_ready, a_mem_read_en, a_mem_read_addr, a_out_data, a_out_valid, a_out_last, a_busy, a_done}
        !== {1'b1, 1'b0, 4'd0, 16'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b en=%b addr=%0d data=%0d v=%b l=%b busy=%b done=%b",
               a_cmd_ready, a_mem_read_en, a_mem_read_addr, a_out_data, a_out_valid, a_out_last, a_busy, a_done);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_burst();
    int t;
    clear_mon();
    a_out_ready = 1'b1;
    send_a(2, 4, 1, t);
    wait_done(1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ra_q.size() != 4 || da_q.size() != 4) begin
      errors++; $display("FAIL burst_count got reads=%0d words=%0d want 4", ra_q.size(), da_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (int'(da_q[k]) != 102 + k || int'(ra_q[k]) != 2 + k || la_q[k] !== (k == 3)) begin
          errors++;
          $display("FAIL burst_word%0d got addr=%0d data=%0d last=%b want addr=%0d data=%0d",
                   k, ra_q[k], da_q[k], la_q[k], 2 + k, 102 + k);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || done_rdy_bad != 0) begin
      errors++; $display("FAIL burst_done got cnt=%0d rdybad=%0d want 1/0", done_cnt, done_rdy_bad);
    end
    checks++;
    if (first_rd != t || first_ov != t + 1 || done_cyc != t + 5) begin
      errors++;
      $display("FAIL burst_timing got rd=%0d ov=%0d done=%0d want %0d %0d %0d",
               first_rd, first_ov, done_cyc, t, t + 1, t + 5);
    end
  endtask

  task automatic test_backpressure();
    int t;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    clear_mon();
    a_out_ready = 1'b1;
    send_a(2, 4, 1, t);
    for (int k = 0; k < 100 && done_cnt < 1; k++) begin
      a_out_ready = pat[k % 4];
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    wait_done(1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ra_q.size() != 4 || da_q.size() != 4) begin
      errors++; $display("FAIL bp_count got reads=%0d words=%0d want 4", ra_q.size(), da_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (int'(da_q[k]) != 102 + k || la_q[k] !== (k == 3)) begin
          errors++; $display("FAIL bp_word%0d got %0d last=%b want %0d", k, da_q[k], la_q[k], 102 + k);
        end
      end
    end
    checks++;
    if (hold_viol != 0 || stall_cnt == 0) begin
      errors++; $display("FAIL bp_hold got viol=%0d stalls=%0d want 0/>0", hold_viol, stall_cnt);
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL bp_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_len0();
    int t;
    clear_mon();
    send_a(5, 0, 3, t);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 1 || done_cyc != t) begin
      errors++; $display("FAIL len0_done got cnt=%0d cyc=%0d want 1/%0d", done_cnt, done_cyc, t);
    end
    checks++;
    if (ra_q.size() != 0 || first_ov != -1 || busy_seen != 0) begin
      errors++;
      $display("FAIL len0_quiet got reads=%0d ov=%0d busy=%0d want 0/-1/0", ra_q.size(), first_ov, busy_seen);
    end
  endtask

  task automatic test_stride0();
    int t;
    clear_mon();
    a_out_ready = 1'b1;
    send_a(7, 3, 0, t);
    wait_done(1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ra_q.size() != 3 || da_q.size() != 3) begin
      errors++; $display("FAIL stride0_count got reads=%0d words=%0d want 3", ra_q.size(), da_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (da_q[k] !== 16'd107 || ra_q[k] !== 4'd7) begin
          errors++; $display("FAIL stride0_word%0d got addr=%0d data=%0d want 7/107", k, ra_q[k], da_q[k]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int ea [4] = '{10, 1, 4, 7};
    clear_mon();
    b_out_ready = 1'b1;
    checks++;
    if (b_cmd_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready got %b want 1", b_cmd_ready); end
    b_cmd_valid = 1'b1; b_cmd_addr = 4'd10; b_cmd_len = 16'd4; b_cmd_stride = 4'd3;
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
    for (int k = 0; k < 100 && b_done_cnt < 1; k++) begin @(posedge clk); #1; end
    checks++;
    if (rb_q.size() != 4 || db_q.size() != 4 || b_done_cnt != 1) begin
      errors++;
      $display("FAIL wrap_count got reads=%0d words=%0d done=%0d want 4/4/1", rb_q.size(), db_q.size(), b_done_cnt);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (int'(rb_q[k]) != ea[k] || int'(db_q[k]) != ea[k] + 100) begin
          errors++;
          $display("FAIL wrap_word%0d got addr=%0d data=%0d want %0d/%0d", k, rb_q[k], db_q[k], ea[k], ea[k] + 100);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int t;
    clear_mon();
    a_out_ready = 1'b1;
    send_a(0, 6, 1, t);
    for (int k = 0; k < 100 && da_q.size() < 2; k++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_cmd_ready, a_mem_read_en, a_mem_read_addr, a_out_data, a_out_valid, a_out_last, a_busy, a_done}
        !== {1'b1, 1'b0, 4'd0, 16'd0, 4'b0000}) begin
      errors++;
      $display("FAIL midrst_outputs got rdy=%b en=%b addr=%0d data=%0d v=%b l=%b busy=%b done=%b",
               a_cmd_ready, a_mem_read_en, a_mem_read_addr, a_out_data, a_out_valid, a_out_last, a_busy, a_done);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL midrst_nodone got %0d want 0", done_cnt); end
    clear_mon();
    send_a(0, 2, 1, t);
    wait_done(1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (da_q.size() != 2 || ra_q.size() != 2 || done_cnt != 1) begin
      errors++;
      $display("FAIL midrst_after got words=%0d reads=%0d done=%0d want 2/2/1", da_q.size(), ra_q.size(), done_cnt);
    end else if (da_q[0] !== 16'd100 || da_q[1] !== 16'd101 || la_q[1] !== 1'b1) begin
      errors++; $display("FAIL midrst_after_data got %0d,%0d want 100,101", da_q[0], da_q[1]);
    end
  endtask

  task automatic test_back_to_back();
    int ea [5] = '{8, 10, 12, 1, 6};
    clear_mon();
    a_out_ready = 1'b1;
    a_cmd_valid = 1'b1; a_cmd_addr = 4'd8; a_cmd_len = 16'd3; a_cmd_stride = 4'd2;
    @(posedge clk); #1;
    a_cmd_addr = 4'd1; a_cmd_len = 16'd2; a_cmd_stride = 4'd5;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (a_done) break;
    end
    checks++;
    if (a_done !== 1'b1 || a_cmd_ready !== 1'b1 || ra_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_first got done=%b rdy=%b reads=%0d want 1/1/3", a_done, a_cmd_ready, ra_q.size());
    end
    @(posedge clk); #1;
    a_cmd_valid = 1'b0;
    wait_done(2);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ra_q.size() != 5 || da_q.size() != 5 || done_cnt != 2) begin
      errors++;
      $display("FAIL b2b_count got reads=%0d words=%0d done=%0d want 5/5/2", ra_q.size(), da_q.size(), done_cnt);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (int'(ra_q[k]) != ea[k] || int'(da_q[k]) != ea[k] + 100) begin
          errors++;
          $display("FAIL b2b_word%0d got addr=%0d data=%0d want %0d/%0d", k, ra_q[k], da_q[k], ea[k], ea[k] + 100);
        end
      end
    end
  endtask

  initial begin
    a_cmd_valid = 1'b0; a_cmd_addr = '0; a_cmd_len = '0; a_cmd_stride = '0; a_out_ready = 1'b0;
    b_cmd_valid = 1'b0; b_cmd_addr = '0; b_cmd_len = '0; b_cmd_stride = '0; b_out_ready = 1'b1;
    inv_bad = 0;
    clear_mon();
    test_reset();
    test_burst();
    test_backpressure();
    test_len0();
    test_stride0();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    checks++;
    if (inv_bad != 0) begin errors++; $display("FAIL ready_busy_invariant got %0d want 0", inv_bad); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Read-side initiator for the on-chip `memory` macro. It accepts a burst command (base address, word count, address stride) over a valid/ready handshake. It then drives the memory's asynchronous read port and presents the fetched words as a valid/ready output stream with backpressure and a last-word marker. It sits between a memory instance and a compute/consumer datapath. It asserts `mem_read_en` only in cycles where a word is actually captured, so the read-energy count equals the number of words delivered.

## Interface
Parameters:
- `WIDTH`, 16, data word width; must match the attached memory.
- `HEIGHT`, 1024, memory depth; address width is `$clog2(HEIGHT)`.
- `LEN_WIDTH`, 16, width of the burst-length field.

Ports (`AW = $clog2(HEIGHT)`):
- `clk`  in  1  single clock; all state on rising edge.
- `arst_n_in`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command (high only in IDLE).
- `cmd_addr`  in  AW  first word address.
- `cmd_len`  in  LEN_WIDTH  words to read; 0 = empty burst.
- `cmd_stride`  in  AW  address increment per word, unsigned, must be < HEIGHT.
- `mem_read_addr`  out  AW  to memory `read_addr`.
- `mem_read_en`  out  1  to memory `read_en`.
- `mem_qout`  in  WIDTH  from memory `qout` (combinational, same cycle).
- `out_data`  out  WIDTH  stream data (registered).
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  consumer accepts word.
- `out_last`  out  1  qualifies final word of burst.
- `busy`  out  1  high in READ or DRAIN.
- `done`  out  1  one-cycle pulse at burst completion.

## Operation
- State machine with three states.
- **IDLE:**
  - `cmd_ready=1`.
  - On `cmd_valid` with `cmd_len!=0`: latch addr, len and stride into `cur_addr`, `remaining` and `stride`; go to READ.
  - On `cmd_valid` with `cmd_len==0`: accept, stay in IDLE, pulse `done` next cycle; no memory access.
- **READ:**
  - Define `fire = (remaining!=0) && (!out_valid || out_ready)`.
  - `mem_read_en = fire`; `mem_read_addr = cur_addr` (driven continuously).
  - On `fire`:
    - `out_data <= mem_qout`; `out_valid <= 1`; `out_last <= (remaining==1)`.
    - `remaining--`.
    - `cur_addr <= cur_addr+stride`, wrapped: subtract HEIGHT if the sum is >= HEIGHT. The sum is computed at AW+1 bits.
  - On `fire` with `remaining==1`: go to DRAIN.
  - Without `fire`, if `out_valid && out_ready`: `out_valid <= 0`.
- **DRAIN:**
  - No reads.
  - On `out_valid && out_ready` (last word): clear `out_valid` and `out_last`, pulse `done`, go to IDLE.
- `out_data`, `out_last` and `out_valid` hold stable while `out_valid && !out_ready`. This is the standard no-retraction rule.
- `busy = (state != IDLE)`.
- `mem_read_en` never asserts in IDLE or DRAIN.

## Timing
- Reset (async assert, sync-safe deassert) values:
  - state = IDLE, so `cmd_ready=1`.
  - `mem_read_en=0`, `mem_read_addr=0`, `out_data=0`, `out_valid=0`, `out_last=0`, `busy=0`, `done=0`.
  - `remaining=0`.
- Command accepted at edge T; first `mem_read_en` in cycle T+1; first `out_valid` in cycle T+2.
- With `out_ready` held high: one word per cycle. An N-word burst ends with `done` in cycle T+N+2, and `cmd_ready` returns the same cycle.
- Backpressure: a word is read only when the output register is empty or draining that cycle. There are no duplicate or dropped reads, and the `mem_read_en` count equals `cmd_len`.
- Wrap-around: the address sequence is `(cmd_addr + k*stride) mod HEIGHT`; this also holds for non-power-of-two HEIGHT.
- `stride=0` re-reads the same word `cmd_len` times.
- `cmd_valid` while busy is ignored (`cmd_ready=0`); there is no queuing.
- Reset mid-burst returns all outputs to their reset values immediately. The remainder of the burst is discarded and no `done` is issued.

## Test plan
- HEIGHT=16, mem[i]=i+100. cmd addr=2, len=4, stride=1, `out_ready=1` -> `out_data` 102,103,104,105 on consecutive cycles; `out_last` on 105; `done` once; exactly 4 `mem_read_en` cycles.
- Same command, `out_ready` toggling 1,0,0,1,... -> identical data sequence; each word held while stalled; `mem_read_en` count = 4.
- HEIGHT=12, addr=10, len=4, stride=3 -> addresses 10,1,4,7 and matching data.
- cmd len=0 -> `done` pulse one cycle after accept; `mem_read_en`, `out_valid` and `busy` never high.
- Assert `arst_n_in` low after 2 of 6 words -> all outputs at reset values within the reset cycle. A new command (addr=0, len=2) then completes normally.
- `cmd_valid` held high with a second command during a burst -> second command not accepted until `cmd_ready`; it then executes after `done`.
